reg_bus_arbiter: RTL

- Shares the control-register host bus (cs/we/oe/adr/dat) between two requesters: A = external MCU bridge, B = internal sequencer/config loader.
- Converts each requester's single-word req/ack transaction into a correctly timed strobe sequence for the register block. That block synchronises cs/we/oe and edge-detects writes, so it needs held strobes and an inter-access gap.
- Round-robin arbitration, one transaction in flight, read data returned to the owning requester.

---
 rtl/reg_bus_arbiter_pkg.sv | 20 ++
 rtl/reg_bus_arbiter_if.sv | 44 ++++
 rtl/reg_bus_arbiter_rr.sv | 17 +
 rtl/reg_bus_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/reg_bus_arbiter_pkg.sv
// Shared definitions for the register-bus arbiter: FSM state encoding,
// default timing parameters and requester identifiers.
package reg_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_SETUP   = 3'd1,
    ARB_STROBE  = 3'd2,
    ARB_CAPTURE = 3'd3,
    ARB_RECOVER = 3'd4
  } arb_state_t;

  localparam int DEF_STROBE_CYC = 4;
  localparam int DEF_GAP_CYC    = 3;
  localparam int DEF_ADR_W      = 7;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Bundle of both requester handshakes plus the register host bus.
// master = requesters/register block side, slave = the arbiter.
interface reg_bus_arbiter_if #(
  parameter int ADR_W = 7
);
  logic             a_req_i;
  logic             a_we_i;
  logic [ADR_W-1:0] a_adr_i;
  logic [15:0]      a_wdat_i;
  logic             a_ack_o;
  logic [15:0]      a_rdat_o;

  logic             b_req_i;
  logic             b_we_i;
  logic [ADR_W-1:0] b_adr_i;
  logic [15:0]      b_wdat_i;
  logic             b_ack_o;
  logic [15:0]      b_rdat_o;

  logic             cs_o;
  logic             we_o;
  logic             oe_o;
  logic [ADR_W-1:0] adr_o;
  logic [15:0]      dat_o;
  logic [15:0]      dat_i;

  modport master (
    output a_req_i, a_we_i, a_adr_i, a_wdat_i,
    input  a_ack_o, a_rdat_o,
    output b_req_i, b_we_i, b_adr_i, b_wdat_i,
    input  b_ack_o, b_rdat_o,
    input  cs_o, we_o, oe_o, adr_o, dat_o,
    output dat_i
  );

  modport slave (
    input  a_req_i, a_we_i, a_adr_i, a_wdat_i,
    output a_ack_o, a_rdat_o,
    input  b_req_i, b_we_i, b_adr_i, b_wdat_i,
    output b_ack_o, b_rdat_o,
    output cs_o, we_o, oe_o, adr_o, dat_o,
    input  dat_i
  );
endinterface

// File: rtl/reg_bus_arbiter_rr.sv
// Two-way round-robin grant picker; purely combinational.
// On contention the side that did not win last time is chosen.
module reg_arb_rr
  import reg_bus_arbiter_pkg::*;
(
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_last_owner,
  output logic o_gnt_vld,
  output logic o_gnt_id
);

  assign o_gnt_vld = i_req_a | i_req_b;
  assign o_gnt_id  = (i_req_a && i_req_b) ? ~i_last_owner
                   : (i_req_b ? OWNER_B : OWNER_A);

endmodule

// File: rtl/reg_bus_arbiter.sv
// Arbitrates two single-word requesters onto the control-register host bus,
// producing held cs/we/oe strobes followed by a recovery gap.
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int GAP_CYC    = DEF_GAP_CYC,
  parameter int ADR_W      = DEF_ADR_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  reg_bus_arbiter_if.slave bus,
  output logic             busy_o,
  output logic             owner_o
);

  generate
    if (STROBE_CYC < 3 || STROBE_CYC > 15) begin : g_bad_strobe
      $error("STROBE_CYC must be within 3..15");
    end
    if (GAP_CYC < 2 || GAP_CYC > 15) begin : g_bad_gap
      $error("GAP_CYC must be within 2..15");
    end
  endgenerate

  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC);
  localparam logic [3:0] GAP_LD    = 4'(GAP_CYC);

  arb_state_t       r_state;
  logic [3:0]       r_cnt;
  logic             r_rr_last;
  logic             r_owner;
  logic             r_busy;
  logic             r_acc_we;
  logic             r_cs;
  logic             r_we;
  logic             r_oe;
  logic [ADR_W-1:0] r_adr;
  logic [15:0]      r_dat;
  logic             r_a_ack;
  logic             r_b_ack;
  logic [15:0]      r_a_rdat;
  logic [15:0]      r_b_rdat;

  logic             w_gnt_vld;
  logic             w_gnt_id;
  logic             w_sel_we;
  logic [ADR_W-1:0] w_sel_adr;
  logic [15:0]      w_sel_wdat;

  // r_rr_last resets to B so that A wins the first contended grant.
  reg_arb_rr u_rr (
    .i_req_a     (bus.a_req_i),
    .i_req_b     (bus.b_req_i),
    .i_last_owner(r_rr_last),
    .o_gnt_vld   (w_gnt_vld),
    .o_gnt_id    (w_gnt_id)
  );

  assign w_sel_we   = (w_gnt_id == OWNER_B) ? bus.b_we_i   : bus.a_we_i;
  assign w_sel_adr  = (w_gnt_id == OWNER_B) ? bus.b_adr_i  : bus.a_adr_i;
  assign w_sel_wdat = (w_gnt_id == OWNER_B) ? bus.b_wdat_i : bus.a_wdat_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ARB_IDLE;
      r_cnt     <= 4'd0;
      r_rr_last <= OWNER_B;
      r_owner   <= OWNER_A;
      r_busy    <= 1'b0;
      r_acc_we  <= 1'b0;
      r_cs      <= 1'b0;
      r_we      <= 1'b0;
      r_oe      <= 1'b0;
      r_adr     <= '0;
      r_dat     <= 16'h0000;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_a_rdat  <= 16'h0000;
      r_b_rdat  <= 16'h0000;
    end else begin
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_gnt_vld) begin
            r_state   <= ARB_SETUP;
            r_busy    <= 1'b1;
            r_owner   <= w_gnt_id;
            r_rr_last <= w_gnt_id;
            r_acc_we  <= w_sel_we;
            r_adr     <= w_sel_adr;
            // Reads leave the previous write data parked on dat_o.
            if (w_sel_we) begin
              r_dat <= w_sel_wdat;
            end
          end
        end
        ARB_SETUP: begin
          r_state <= ARB_STROBE;
          r_cnt   <= STROBE_LD;
          r_cs    <= 1'b1;
          r_we    <= r_acc_we;
          r_oe    <= ~r_acc_we;
        end
        ARB_STROBE: begin
          if (r_cnt == 4'd1) begin
            r_state <= ARB_CAPTURE;
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_oe    <= 1'b0;
            if (r_owner == OWNER_B) begin
              r_b_ack <= 1'b1;
              if (!r_acc_we) begin
                r_b_rdat <= bus.dat_i;
              end
            end else begin
              r_a_ack <= 1'b1;
              if (!r_acc_we) begin
                r_a_rdat <= bus.dat_i;
              end
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ARB_CAPTURE: begin
          r_state <= ARB_RECOVER;
          r_cnt   <= GAP_LD;
        end
        ARB_RECOVER: begin
          if (r_cnt == 4'd1) begin
            r_state <= ARB_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cs_o     = r_cs;
  assign bus.we_o     = r_we;
  assign bus.oe_o     = r_oe;
  assign bus.adr_o    = r_adr;
  assign bus.dat_o    = r_dat;
  assign bus.a_ack_o  = r_a_ack;
  assign bus.b_ack_o  = r_b_ack;
  assign bus.a_rdat_o = r_a_rdat;
  assign bus.b_rdat_o = r_b_rdat;
  assign busy_o       = r_busy;
  assign owner_o      = r_owner;

endmodule
